// File: rtl/pkt_sequencer.sv
// Long-packet payload sequencer: tracks frame start/end, forwards payload beats of the
// selected virtual channel, consumes the CRC beat, and drops packets it is not forwarding.
module pkt_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    rxbyteclkhs,
    input  logic                    reset,
    input  logic [23:0]             ph_in,
    input  logic                    ph_select,
    input  logic                    ecc_error,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    input  logic [1:0]              vc_select,
    output logic [DATA_WIDTH-1:0]   out_stream,
    output logic                    out_valid,
    output logic [DATA_WIDTH/8-1:0] out_keep,
    output logic                    frame_active,
    output logic                    frame_valid,
    output logic                    line_valid,
    output logic                    pkt_error
);
    // state   | meaning
    // IDLE    | waiting for a packet header
    // PAYLOAD | forwarding payload beats of the selected channel
    // CRC     | consuming the trailing CRC beat of a forwarded packet
    // DROP    | consuming payload plus CRC of a skipped packet

    localparam int KW = DATA_WIDTH / 8;
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DROP} state_t;

    state_t                  state, state_n;
    logic [15:0]             cnt, cnt_n;
    logic [GW-1:0]           gap, gap_n;
    logic                    odd, odd_n;
    logic [DATA_WIDTH-1:0]   stream_n;
    logic                    valid_n;
    logic [KW-1:0]           keep_n;
    logic                    fa_n, fv_n, lv_n, err_n;

    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    logic [15:0] half;

    assign dt   = ph_in[5:0];
    assign vc   = ph_in[7:6];
    assign wc   = ph_in[23:8];
    assign half = 16'((17'(wc) + 17'd1) >> 1);

    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            gap          <= '0;
            odd          <= 1'b0;
            out_stream   <= '0;
            out_valid    <= 1'b0;
            out_keep     <= '0;
            frame_active <= 1'b0;
            frame_valid  <= 1'b0;
            line_valid   <= 1'b0;
            pkt_error    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            gap          <= gap_n;
            odd          <= odd_n;
            out_stream   <= stream_n;
            out_valid    <= valid_n;
            out_keep     <= keep_n;
            frame_active <= fa_n;
            frame_valid  <= fv_n;
            line_valid   <= lv_n;
            pkt_error    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gap_n    = gap;
        odd_n    = odd;
        stream_n = '0;
        valid_n  = 1'b0;
        keep_n   = '0;
        fa_n     = frame_active;
        fv_n     = frame_valid;
        lv_n     = line_valid;
        err_n    = 1'b0;

        case (state)
            IDLE: begin
                gap_n = GAP_INIT;
                lv_n  = 1'b0;
                if (ph_select) begin
                    if (ecc_error) begin
                        err_n = 1'b1;
                    end else if (dt == 6'h00) begin
                        fa_n = 1'b1;
                        if (frame_active) begin
                            err_n = 1'b1;
                            fv_n  = 1'b0;
                        end
                    end else if (dt == 6'h01) begin
                        fa_n  = 1'b0;
                        fv_n  = 1'b0;
                        err_n = !frame_active;
                    end else if (dt >= 6'h10) begin
                        odd_n = wc[0];
                        if (vc == vc_select && frame_active) begin
                            cnt_n   = half;
                            state_n = (half == 16'd0) ? CRC : PAYLOAD;
                        end else begin
                            // skipped packets also swallow their CRC beat
                            cnt_n   = half + 16'd1;
                            state_n = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (data_valid) begin
                    stream_n = data_in;
                    valid_n  = 1'b1;
                    lv_n     = 1'b1;
                    fv_n     = 1'b1;
                    cnt_n    = cnt - 16'd1;
                    keep_n   = (cnt == 16'd1 && odd) ? KW'(1) : '1;
                    if (cnt == 16'd1) state_n = CRC;
                end
            end
            CRC: begin
                lv_n = 1'b0;
                if (data_valid) state_n = IDLE;
            end
            DROP: begin
                if (data_valid) begin
                    cnt_n = cnt - 16'd1;
                    if (cnt == 16'd1) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // gap timer runs in every packet state; a beat reloads it
        if (state != IDLE) begin
            if (data_valid) begin
                gap_n = GAP_INIT;
            end else if (gap == '0) begin
                err_n   = 1'b1;
                lv_n    = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                gap_n = gap - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pkt_sequencer.sv
// Self-checking bench for pkt_sequencer: directed scenarios plus a randomized packet mix
// compared against a packet-level model (expected beats, frame flags, error count).
module tb_pkt_sequencer;
    logic        rxbyteclkhs = 1'b0;
    logic        reset;
    logic [23:0] ph_in;
    logic        ph_select, ecc_error;
    logic [15:0] data_in;
    logic        data_valid;
    logic [1:0]  vc_select;
    logic [15:0] out_stream;
    logic        out_valid;
    logic [1:0]  out_keep;
    logic        frame_active, frame_valid, line_valid, pkt_error;

    always #5 rxbyteclkhs = ~rxbyteclkhs;

    pkt_sequencer #(.DATA_WIDTH(16), .TIMEOUT(255)) dut (
        .rxbyteclkhs(rxbyteclkhs), .reset(reset), .ph_in(ph_in), .ph_select(ph_select),
        .ecc_error(ecc_error), .data_in(data_in), .data_valid(data_valid),
        .vc_select(vc_select), .out_stream(out_stream), .out_valid(out_valid),
        .out_keep(out_keep), .frame_active(frame_active), .frame_valid(frame_valid),
        .line_valid(line_valid), .pkt_error(pkt_error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int exp_err  = 0;
    bit m_fa = 1'b0;
    bit m_fv = 1'b0;
    logic [15:0] exp_data[$], got_data[$];
    logic [1:0]  exp_keep[$], got_keep[$];

    always @(negedge rxbyteclkhs) begin
        if (out_valid) begin
            got_data.push_back(out_stream);
            got_keep.push_back(out_keep);
        end
        if (pkt_error) err_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rxbyteclkhs);
        #1;
    endtask

    task automatic settle();
        repeat (2) tick();
    endtask

    task automatic clear_q();
        exp_data.delete(); exp_keep.delete(); got_data.delete(); got_keep.delete();
    endtask

    function automatic int first_bad();
        if (got_data.size() != exp_data.size()) return -2;
        foreach (got_data[i])
            if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i]) return i;
        return -1;
    endfunction

    // drive one header and update the frame-level model
    task automatic hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                       input logic ecc);
        ph_in = {wc, vc, dt}; ph_select = 1'b1; ecc_error = ecc;
        tick();
        ph_select = 1'b0; ecc_error = 1'b0;
        if (ecc) exp_err++;
        else if (dt == 6'h00) begin
            if (m_fa) begin exp_err++; m_fv = 1'b0; end
            m_fa = 1'b1;
        end else if (dt == 6'h01) begin
            if (!m_fa) exp_err++;
            m_fa = 1'b0; m_fv = 1'b0;
        end
    endtask

    task automatic beat(input logic [15:0] d);
        data_in = d; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // long packet: ceil(wc/2) payload beats plus one CRC beat, with random idle gaps
    task automatic send_long(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                             input int maxgap);
        bit fwd;
        int n;
        logic [15:0] d;
        fwd = m_fa && (vc == vc_select);
        n = (int'(wc) + 1) / 2;
        hdr(dt, vc, wc, 1'b0);
        for (int i = 0; i <= n; i++) begin
            repeat ($urandom_range(0, maxgap)) tick();
            d = 16'($urandom);
            if (fwd && i < n) begin
                exp_data.push_back(d);
                exp_keep.push_back((i == n - 1 && wc[0]) ? 2'b01 : 2'b11);
            end
            beat(d);
        end
        if (fwd && n > 0) m_fv = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++; if (out_stream !== 16'h0) begin n_fail++; $display("FAIL reset out_stream: got %h want 0", out_stream); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_keep !== 2'b00) begin n_fail++; $display("FAIL reset out_keep: got %b want 00", out_keep); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL reset frame_active: got %b want 0", frame_active); end
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset frame_valid: got %b want 0", frame_valid); end
        n_tests++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset line_valid: got %b want 0", line_valid); end
        n_tests++; if (pkt_error !== 1'b0) begin n_fail++; $display("FAIL reset pkt_error: got %b want 0", pkt_error); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int k;
        clear_q();
        vc_select = 2'd0;
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        n_tests++; if (frame_active !== 1'b1) begin n_fail++; $display("FAIL basic fs frame_active: got %b want 1", frame_active); end
        send_long(6'h2A, 2'd0, 16'd6, 0);
        settle();
        k = first_bad();
        n_tests++; if (k != -1) begin n_fail++; $display("FAIL basic beats: first bad %0d, got %0d beats want %0d", k, got_data.size(), exp_data.size()); end
        n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL basic beat count: got %0d want 3", got_data.size()); end
        n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic frame_valid: got %b want 1", frame_valid); end
        n_tests++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL basic line_valid after last: got %b want 0", line_valid); end
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL basic fe frame_active: got %b want 0", frame_active); end
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic fe frame_valid: got %b want 0", frame_valid); end
        settle();
        n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL basic errors: got %0d want %0d", err_seen, exp_err); end
    endtask

    task automatic test_odd();
        int k;
        clear_q();
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        send_long(6'h12, 2'd0, 16'd5, 2);
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL odd next header frame_active: got %b want 0", frame_active); end
        settle();
        k = first_bad();
        n_tests++; if (k != -1) begin n_fail++; $display("FAIL odd beats: first bad %0d, got %0d beats want %0d", k, got_data.size(), exp_data.size()); end
        n_tests++; if (got_keep.size() != 3 || got_keep[2] !== 2'b01) begin n_fail++; $display("FAIL odd last keep: got %0d beats want 3 with last keep 01", got_keep.size()); end
        n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL odd errors: got %0d want %0d", err_seen, exp_err); end
    endtask

    task automatic test_drop();
        clear_q();
        vc_select = 2'd0;
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        send_long(6'h2B, 2'd2, 16'($urandom_range(1, 30)), 1);
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        settle();
        n_tests++; if (got_data.size() != 0) begin n_fail++; $display("FAIL drop out beats: got %0d want 0", got_data.size()); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL drop back to idle frame_active: got %b want 0", frame_active); end
        n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL drop errors: got %0d want %0d", err_seen, exp_err); end
    endtask

    task automatic test_errors();
        hdr(6'h00, 2'd0, 16'd0, 1'b1);
        settle();
        n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL ecc error count: got %0d want %0d", err_seen, exp_err); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL ecc frame_active: got %b want 0", frame_active); end
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        settle();
        n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL stray fe error count: got %0d want %0d", err_seen, exp_err); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL stray fe frame_active: got %b want 0", frame_active); end
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        hdr(6'h01, 2'd0, 16'd0, 1'b1);
        settle();
        n_tests++; if (frame_active !== 1'b1) begin n_fail++; $display("FAIL ecc fe frame_active: got %b want 1", frame_active); end
        hdr(6'h07, 2'd1, 16'd33, 1'b0);
        settle();
        n_tests++; if (err_seen != exp_err || frame_active !== 1'b1) begin n_fail++; $display("FAIL short pkt: errors %0d want %0d, frame_active %b want 1", err_seen, exp_err, frame_active); end
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        settle();
        n_tests++; if (err_seen != exp_err || frame_active !== 1'b1) begin n_fail++; $display("FAIL repeated fs: errors %0d want %0d, frame_active %b want 1", err_seen, exp_err, frame_active); end
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        settle();
    endtask

    task automatic test_timeout();
        clear_q();
        vc_select = 2'd0;
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        hdr(6'h1E, 2'd0, 16'd20, 1'b0);
        repeat (3) beat(16'($urandom));
        m_fv = 1'b1;
        for (int i = 0; i < 254; i++) begin
            if (i == 100) begin
                ph_in = {16'd0, 2'd0, 6'h01}; ph_select = 1'b1;
            end else begin
                ph_select = 1'b0;
            end
            tick();
        end
        n_tests++; if (pkt_error !== 1'b0 || err_seen != exp_err) begin n_fail++; $display("FAIL timeout early: pkt_error %b, errors %0d want %0d", pkt_error, err_seen, exp_err); end
        n_tests++; if (line_valid !== 1'b1) begin n_fail++; $display("FAIL timeout line_valid in gap: got %b want 1", line_valid); end
        n_tests++; if (frame_active !== 1'b1) begin n_fail++; $display("FAIL header outside idle: frame_active %b want 1", frame_active); end
        tick();
        exp_err++;
        n_tests++; if (pkt_error !== 1'b1) begin n_fail++; $display("FAIL timeout pulse: got %b want 1", pkt_error); end
        n_tests++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL timeout line_valid: got %b want 0", line_valid); end
        n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL timeout beats: got %0d want 3", got_data.size()); end
        settle();
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        settle();
        n_tests++; if (frame_active !== 1'b1 || err_seen != exp_err) begin n_fail++; $display("FAIL fs after timeout: frame_active %b want 1, errors %0d want %0d", frame_active, err_seen, exp_err); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d1;
        clear_q();
        d1 = 16'($urandom);
        hdr(6'h20, 2'd0, 16'd10, 1'b0);
        beat(d1);
        data_in = 16'($urandom); data_valid = 1'b1; reset = 1'b1;
        tick();
        n_tests++; if ({out_stream, out_valid, out_keep, frame_active, frame_valid, line_valid, pkt_error} !== 22'h0) begin
            n_fail++; $display("FAIL mid reset outputs: got %h/%b/%b fa%b fv%b lv%b err%b want all 0",
                               out_stream, out_valid, out_keep, frame_active, frame_valid, line_valid, pkt_error); end
        data_valid = 1'b0; reset = 1'b0;
        m_fa = 1'b0; m_fv = 1'b0;
        hdr(6'h00, 2'd0, 16'd0, 1'b0);
        n_tests++; if (frame_active !== 1'b1 || pkt_error !== 1'b0) begin n_fail++; $display("FAIL fs after reset: frame_active %b want 1, pkt_error %b want 0", frame_active, pkt_error); end
        settle();
        n_tests++; if (got_data.size() != 1 || got_data[0] !== d1) begin n_fail++; $display("FAIL mid reset beats: got %0d beats want 1 (%h)", got_data.size(), d1); end
        hdr(6'h01, 2'd0, 16'd0, 1'b0);
        settle();
    endtask

    task automatic test_random();
        int op, k;
        for (int it = 0; it < 200; it++) begin
            clear_q();
            op = $urandom_range(0, 9);
            if (op == 0) begin
                if (!m_fa) vc_select = 2'($urandom_range(0, 3));
                hdr(6'h00, 2'd0, 16'd0, 1'b0);
            end else if (op == 1) hdr(6'h01, 2'd0, 16'd0, 1'b0);
            else if (op == 2) hdr(6'($urandom_range(2, 15)), 2'($urandom), 16'($urandom), 1'b0);
            else if (op == 3) hdr(6'($urandom), 2'($urandom), 16'($urandom), 1'b1);
            else send_long(6'($urandom_range(16, 63)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 40)), 3);
            settle();
            k = first_bad();
            n_tests++; if (k != -1) begin n_fail++; $display("FAIL random beats op%0d it%0d: first bad %0d, got %0d want %0d", op, it, k, got_data.size(), exp_data.size()); end
            n_tests++; if (frame_active !== m_fa) begin n_fail++; $display("FAIL random frame_active it%0d: got %b want %b", it, frame_active, m_fa); end
            n_tests++; if (frame_valid !== m_fv) begin n_fail++; $display("FAIL random frame_valid it%0d: got %b want %b", it, frame_valid, m_fv); end
            n_tests++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL random line_valid it%0d: got %b want 0", it, line_valid); end
            n_tests++; if (err_seen != exp_err) begin n_fail++; $display("FAIL random errors it%0d: got %0d want %0d", it, err_seen, exp_err); end
        end
    endtask

    initial begin
        reset = 1'b1; ph_in = '0; ph_select = 1'b0; ecc_error = 1'b0;
        data_in = '0; data_valid = 1'b0; vc_select = 2'd0;
        test_reset();
        test_basic();
        test_odd();
        test_drop();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
